// File: rtl/shot_bitmap_reader_if.sv
// Shot bitmap bus: VGA scan position, sprite placement and bitmap in; registered
// draw request, colour and blink status out.
interface shot_bitmap_reader_if #(
  parameter int OBJECT_WIDTH_X  = 16,
  parameter int OBJECT_HEIGHT_Y = 16
);
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic [OBJECT_HEIGHT_Y-1:0][OBJECT_WIDTH_X-1:0][7:0] object_colors;
  logic        enable;
  logic        startOfFrame;
  logic        hit;
  logic        drawingRequest;
  logic [7:0]  RGBout;
  logic        blinking;

  modport master (
    output pixelX, pixelY, topLeftX, topLeftY, object_colors,
    output enable, startOfFrame, hit,
    input  drawingRequest, RGBout, blinking
  );

  modport slave (
    input  pixelX, pixelY, topLeftX, topLeftY, object_colors,
    input  enable, startOfFrame, hit,
    output drawingRequest, RGBout, blinking
  );
endinterface

// File: rtl/shot_bitmap_reader.sv
// Shot sprite reader: maps the scan pixel onto an upscaled 16x16 bitmap, applies the
// colour key and a frame-counted blink after a hit, and registers the result.
module shot_bitmap_reader #(
  parameter int         OBJECT_WIDTH_X  = 16,
  parameter int         OBJECT_HEIGHT_Y = 16,
  parameter int         SCALE_SHIFT     = 0,
  parameter logic [7:0] TRANSPARENT     = 8'hFF,
  parameter int         BLINK_FRAMES    = 8,
  parameter int         BLINK_PERIOD    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  shot_bitmap_reader_if.slave   bus
);
  localparam int COL_W   = $clog2(OBJECT_WIDTH_X);
  localparam int ROW_W   = $clog2(OBJECT_HEIGHT_Y);
  localparam int FRAME_W = $clog2(BLINK_FRAMES) + 1;
  localparam int PHASE_W = $clog2(BLINK_PERIOD) + 1;

  localparam logic [11:0]        SCALED_W   = 12'(OBJECT_WIDTH_X << SCALE_SHIFT);
  localparam logic [11:0]        SCALED_H   = 12'(OBJECT_HEIGHT_Y << SCALE_SHIFT);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(BLINK_PERIOD - 1);
  localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);
  localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BLINK = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [PHASE_W-1:0] phase_cnt_q, phase_cnt_d;
  logic               visible_q, visible_d;
  logic               drawing_request_q, drawing_request_d;
  logic [7:0]         rgb_q, rgb_d;
  logic               blinking_q, blinking_d;

  logic [11:0]      off_x_s;
  logic [11:0]      off_y_s;
  logic             inside_s;
  logic [COL_W-1:0] col_s;
  logic [ROW_W-1:0] row_s;
  logic [7:0]       tex_s;

  // Sprite-relative offsets; a set sign bit means the pixel lies left of or above the sprite.
  always_comb begin
    off_x_s  = {1'b0, bus.pixelX} - {1'b0, bus.topLeftX};
    off_y_s  = {1'b0, bus.pixelY} - {1'b0, bus.topLeftY};
    inside_s = 1'b0;
    col_s    = {COL_W{1'b0}};
    row_s    = {ROW_W{1'b0}};
    tex_s    = TRANSPARENT;
    if (!off_x_s[11] && !off_y_s[11] && (off_x_s < SCALED_W) && (off_y_s < SCALED_H)) begin
      inside_s = 1'b1;
      col_s    = off_x_s[SCALE_SHIFT +: COL_W];
      row_s    = off_y_s[SCALE_SHIFT +: ROW_W];
      tex_s    = bus.object_colors[row_s][col_s];
    end else begin
      inside_s = 1'b0;
      tex_s    = TRANSPARENT;
    end
  end

  // Blink sequencer: a hit (re)starts it hidden, frames are counted only on startOfFrame.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    phase_cnt_d = phase_cnt_q;
    visible_d   = visible_q;
    case (state_q)
      ST_IDLE: begin
        frame_cnt_d = {FRAME_W{1'b0}};
        phase_cnt_d = {PHASE_W{1'b0}};
        if (bus.hit) begin
          state_d   = ST_BLINK;
          visible_d = 1'b0;
        end else begin
          state_d   = ST_IDLE;
          visible_d = 1'b1;
        end
      end
      ST_BLINK: begin
        if (bus.hit) begin
          frame_cnt_d = {FRAME_W{1'b0}};
          phase_cnt_d = {PHASE_W{1'b0}};
          visible_d   = 1'b0;
        end else if (bus.startOfFrame) begin
          if (frame_cnt_q == FRAME_LAST) begin
            state_d     = ST_IDLE;
            frame_cnt_d = {FRAME_W{1'b0}};
            phase_cnt_d = {PHASE_W{1'b0}};
            visible_d   = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + FRAME_ONE;
            if (phase_cnt_q == PHASE_LAST) begin
              phase_cnt_d = {PHASE_W{1'b0}};
              visible_d   = ~visible_q;
            end else begin
              phase_cnt_d = phase_cnt_q + PHASE_ONE;
            end
          end
        end else begin
          state_d = ST_BLINK;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        frame_cnt_d = {FRAME_W{1'b0}};
        phase_cnt_d = {PHASE_W{1'b0}};
        visible_d   = 1'b1;
      end
    endcase
  end

  // Next-cycle outputs; visibility uses the current register so a hit hides from the next pixel on.
  always_comb begin
    drawing_request_d = inside_s & bus.enable & visible_q & (tex_s != TRANSPARENT);
    rgb_d             = TRANSPARENT;
    if (drawing_request_d) begin
      rgb_d = tex_s;
    end else begin
      rgb_d = TRANSPARENT;
    end
    blinking_d = (state_d == ST_BLINK);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      frame_cnt_q       <= {FRAME_W{1'b0}};
      phase_cnt_q       <= {PHASE_W{1'b0}};
      visible_q         <= 1'b1;
      drawing_request_q <= 1'b0;
      rgb_q             <= TRANSPARENT;
      blinking_q        <= 1'b0;
    end else begin
      state_q           <= state_d;
      frame_cnt_q       <= frame_cnt_d;
      phase_cnt_q       <= phase_cnt_d;
      visible_q         <= visible_d;
      drawing_request_q <= drawing_request_d;
      rgb_q             <= rgb_d;
      blinking_q        <= blinking_d;
    end
  end

  assign bus.drawingRequest = drawing_request_q;
  assign bus.RGBout         = rgb_q;
  assign bus.blinking       = blinking_q;
endmodule

// File: tb/tb_shot_bitmap_reader.sv
// Randomised and directed bench for shot_bitmap_reader at SCALE_SHIFT 0 and 1,
// checked against a frame-index model of the sprite and its blink sequence.
module tb_shot_bitmap_reader;
  localparam int BF = 8;
  localparam int BP = 2;

  logic clk = 1'b0;
  logic rst;
  logic [10:0] px, py, tlx, tly;
  logic en, sof, hit;
  logic [15:0][15:0][7:0] bmp;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: -1 when idle, else frames elapsed since the last hit.
  int blink_f = -1;
  logic       exp_draw0, exp_draw1, exp_blink;
  logic [7:0] exp_rgb0, exp_rgb1;

  always #5 clk = ~clk;

  shot_bitmap_reader_if #(.OBJECT_WIDTH_X(16), .OBJECT_HEIGHT_Y(16)) if0 ();
  shot_bitmap_reader_if #(.OBJECT_WIDTH_X(16), .OBJECT_HEIGHT_Y(16)) if1 ();

  assign if0.pixelX = px;   assign if1.pixelX = px;
  assign if0.pixelY = py;   assign if1.pixelY = py;
  assign if0.topLeftX = tlx; assign if1.topLeftX = tlx;
  assign if0.topLeftY = tly; assign if1.topLeftY = tly;
  assign if0.object_colors = bmp; assign if1.object_colors = bmp;
  assign if0.enable = en;   assign if1.enable = en;
  assign if0.startOfFrame = sof; assign if1.startOfFrame = sof;
  assign if0.hit = hit;     assign if1.hit = hit;

  shot_bitmap_reader #(.SCALE_SHIFT(0), .TRANSPARENT(8'hFF), .BLINK_FRAMES(BF), .BLINK_PERIOD(BP))
    dut0 (.clk(clk), .reset(rst), .bus(if0.slave));
  shot_bitmap_reader #(.SCALE_SHIFT(1), .TRANSPARENT(8'hFF), .BLINK_FRAMES(BF), .BLINK_PERIOD(BP))
    dut1 (.clk(clk), .reset(rst), .bus(if1.slave));

  // Returns {draw, rgb} for a sprite of scale s at the current inputs.
  function automatic logic [8:0] predict(input int s);
    int ox, oy, sz;
    logic vis;
    logic [7:0] t;
    ox  = int'(px) - int'(tlx);
    oy  = int'(py) - int'(tly);
    sz  = 16 << s;
    vis = (blink_f < 0) ? 1'b1 : (((blink_f / BP) % 2) == 1);
    t   = 8'hFF;
    if (ox >= 0 && ox < sz && oy >= 0 && oy < sz) t = bmp[oy >> s][ox >> s];
    if (en && vis && t != 8'hFF) return {1'b1, t};
    return {1'b0, 8'hFF};
  endfunction

  task automatic clk_step();
    logic [8:0] p0, p1;
    @(posedge clk);
    if (rst) begin
      exp_draw0 = 1'b0; exp_rgb0 = 8'hFF;
      exp_draw1 = 1'b0; exp_rgb1 = 8'hFF;
      blink_f = -1;
    end else begin
      p0 = predict(0);
      p1 = predict(1);
      {exp_draw0, exp_rgb0} = p0;
      {exp_draw1, exp_rgb1} = p1;
      if (hit) blink_f = 0;
      else if (sof && blink_f >= 0) begin
        blink_f++;
        if (blink_f == BF) blink_f = -1;
      end
    end
    exp_blink = (blink_f >= 0);
    #1;
  endtask

  task automatic fill_bmp(input logic [7:0] c);
    for (int r = 0; r < 16; r++)
      for (int k = 0; k < 16; k++) bmp[r][k] = c;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; sof = 1'b0; hit = 1'b0;
    px = 11'd0; py = 11'd0; tlx = 11'd0; tly = 11'd0;
    fill_bmp(8'hE9);
    clk_step();
    clk_step();
    n_checks++;
    if ({if0.drawingRequest, if0.RGBout, if0.blinking} !== {1'b0, 8'hFF, 1'b0})
      $display("FAIL reset dut0 got=%b/%h/%b exp=0/ff/0", if0.drawingRequest, if0.RGBout, if0.blinking);
    else n_pass++;
    n_checks++;
    if ({if1.drawingRequest, if1.RGBout, if1.blinking} !== {1'b0, 8'hFF, 1'b0})
      $display("FAIL reset dut1 got=%b/%h/%b exp=0/ff/0", if1.drawingRequest, if1.RGBout, if1.blinking);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_geometry();
    logic [10:0] tx [6] = '{11'd100, 11'd116, 11'd99, 11'd100, 11'd115, 11'd100};
    logic [10:0] ty [6] = '{11'd50,  11'd50,  11'd50, 11'd49,  11'd65,  11'd66};
    logic        td [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0]  want;
    fill_bmp(8'hE9);
    tlx = 11'd100; tly = 11'd50; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      px = tx[i]; py = ty[i];
      clk_step();
      want = td[i] ? 8'hE9 : 8'hFF;
      n_checks++;
      if ({if0.drawingRequest, if0.RGBout} !== {td[i], want})
        $display("FAIL geom dut0 (%0d,%0d) got=%b/%h exp=%b/%h", tx[i], ty[i], if0.drawingRequest, if0.RGBout, td[i], want);
      else n_pass++;
      n_checks++;
      if ({if1.drawingRequest, if1.RGBout} !== {exp_draw1, exp_rgb1})
        $display("FAIL geom dut1 (%0d,%0d) got=%b/%h exp=%b/%h", tx[i], ty[i], if1.drawingRequest, if1.RGBout, exp_draw1, exp_rgb1);
      else n_pass++;
    end
  endtask

  task automatic test_scaled();
    logic [10:0] tx [8] = '{11'd4, 11'd5, 11'd4, 11'd5, 11'd31, 11'd32, 11'd3, 11'd6};
    logic [10:0] ty [8] = '{11'd2, 11'd2, 11'd3, 11'd3, 11'd31, 11'd0,  11'd2, 11'd2};
    logic        td [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0]  tc [8] = '{8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'hE9, 8'hFF, 8'hE9, 8'hE9};
    fill_bmp(8'hE9);
    bmp[1][2] = 8'h1C;
    tlx = 11'd0; tly = 11'd0; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      px = tx[i]; py = ty[i];
      clk_step();
      n_checks++;
      if ({if1.drawingRequest, if1.RGBout} !== {td[i], tc[i]})
        $display("FAIL scaled dut1 (%0d,%0d) got=%b/%h exp=%b/%h", tx[i], ty[i], if1.drawingRequest, if1.RGBout, td[i], tc[i]);
      else n_pass++;
      n_checks++;
      if ({if0.drawingRequest, if0.RGBout} !== {exp_draw0, exp_rgb0})
        $display("FAIL scaled dut0 (%0d,%0d) got=%b/%h exp=%b/%h", tx[i], ty[i], if0.drawingRequest, if0.RGBout, exp_draw0, exp_rgb0);
      else n_pass++;
    end
  endtask

  task automatic test_transparent();
    fill_bmp(8'hE9);
    bmp[0][0] = 8'hFF;
    tlx = 11'd20; tly = 11'd30; px = 11'd20; py = 11'd30; en = 1'b1;
    clk_step();
    n_checks++;
    if ({if0.drawingRequest, if0.RGBout, if1.drawingRequest, if1.RGBout} !== {1'b0, 8'hFF, 1'b0, 8'hFF})
      $display("FAIL transparent got=%b/%h %b/%h exp=0/ff 0/ff", if0.drawingRequest, if0.RGBout, if1.drawingRequest, if1.RGBout);
    else n_pass++;
  endtask

  task automatic test_blink();
    logic pat [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    rst = 1'b1; clk_step(); rst = 1'b0;
    fill_bmp(8'hE9);
    tlx = 11'd0; tly = 11'd0; px = 11'd0; py = 11'd0; en = 1'b1;
    hit = 1'b1; clk_step(); hit = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (j > 0) begin sof = 1'b1; clk_step(); sof = 1'b0; end
      clk_step();
      n_checks++;
      if ({if0.drawingRequest, if0.blinking} !== {pat[j], 1'b1})
        $display("FAIL blink frame %0d got=%b/%b exp=%b/1", j, if0.drawingRequest, if0.blinking, pat[j]);
      else n_pass++;
      n_checks++;
      if ({if1.drawingRequest, if1.RGBout, if1.blinking} !== {exp_draw1, exp_rgb1, exp_blink})
        $display("FAIL blink model dut1 frame %0d got=%b/%h/%b exp=%b/%h/%b", j, if1.drawingRequest, if1.RGBout, if1.blinking, exp_draw1, exp_rgb1, exp_blink);
      else n_pass++;
    end
    sof = 1'b1; clk_step(); sof = 1'b0;
    clk_step();
    n_checks++;
    if ({if0.drawingRequest, if0.blinking} !== {1'b1, 1'b0})
      $display("FAIL blink end got=%b/%b exp=1/0", if0.drawingRequest, if0.blinking);
    else n_pass++;
    // Restart: four counted frames, then hit and startOfFrame together.
    hit = 1'b1; clk_step(); hit = 1'b0;
    for (int j = 0; j < 4; j++) begin sof = 1'b1; clk_step(); end
    hit = 1'b1; clk_step(); hit = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      clk_step();
      n_checks++;
      if (if0.blinking !== (j < 8))
        $display("FAIL blink restart pulse %0d got=%b exp=%b", j, if0.blinking, (j < 8));
      else n_pass++;
    end
    sof = 1'b0;
    clk_step();
    n_checks++;
    if (if1.blinking !== exp_blink)
      $display("FAIL blink restart dut1 got=%b exp=%b", if1.blinking, exp_blink);
    else n_pass++;
  endtask

  task automatic test_reset_mid_blink_enable();
    fill_bmp(8'hE9);
    tlx = 11'd0; tly = 11'd0; px = 11'd5; py = 11'd5; en = 1'b1;
    hit = 1'b1; clk_step(); hit = 1'b0;
    sof = 1'b1; clk_step(); clk_step(); sof = 1'b0;
    rst = 1'b1; clk_step(); rst = 1'b0;
    n_checks++;
    if ({if0.drawingRequest, if0.RGBout, if0.blinking, if1.blinking} !== {1'b0, 8'hFF, 1'b0, 1'b0})
      $display("FAIL reset mid blink got=%b/%h/%b/%b exp=0/ff/0/0", if0.drawingRequest, if0.RGBout, if0.blinking, if1.blinking);
    else n_pass++;
    en = 1'b0; clk_step();
    n_checks++;
    if ({if0.drawingRequest, if0.RGBout} !== {1'b0, 8'hFF})
      $display("FAIL enable off got=%b/%h exp=0/ff", if0.drawingRequest, if0.RGBout);
    else n_pass++;
    en = 1'b1; clk_step();
    n_checks++;
    if ({if0.drawingRequest, if0.RGBout} !== {1'b1, 8'hE9})
      $display("FAIL enable on got=%b/%h exp=1/e9", if0.drawingRequest, if0.RGBout);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0)
        for (int r = 0; r < 16; r++)
          for (int k = 0; k < 16; k++)
            bmp[r][k] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      if (i % 20 == 0) begin
        tlx = 11'($urandom_range(0, 2047));
        tly = 11'($urandom_range(0, 2047));
      end
      px  = 11'(int'(tlx) + $urandom_range(0, 44) - 6);
      py  = 11'(int'(tly) + $urandom_range(0, 44) - 6);
      en  = ($urandom_range(0, 7) != 0);
      sof = ($urandom_range(0, 3) == 0);
      hit = ($urandom_range(0, 40) == 0);
      clk_step();
      n_checks++;
      if ({if0.drawingRequest, if0.RGBout, if0.blinking} !== {exp_draw0, exp_rgb0, exp_blink})
        $display("FAIL random dut0 cyc %0d got=%b/%h/%b exp=%b/%h/%b", i, if0.drawingRequest, if0.RGBout, if0.blinking, exp_draw0, exp_rgb0, exp_blink);
      else n_pass++;
      n_checks++;
      if ({if1.drawingRequest, if1.RGBout, if1.blinking} !== {exp_draw1, exp_rgb1, exp_blink})
        $display("FAIL random dut1 cyc %0d got=%b/%h/%b exp=%b/%h/%b", i, if1.drawingRequest, if1.RGBout, if1.blinking, exp_draw1, exp_rgb1, exp_blink);
      else n_pass++;
    end
    sof = 1'b0; hit = 1'b0;
  endtask

  initial begin
    test_reset();
    test_geometry();
    test_scaled();
    test_transparent();
    test_blink();
    test_reset_mid_blink_enable();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
